// File: rtl/gmii_rx_framer.sv
// gmii_rx_framer: receive framer for the demultiplexed GMII/RGMII byte stream.
// Strips preamble/SFD, delays each frame byte by one hold stage so the last
// byte can carry EOF, checks CRC-32 residue, length and RX_ER, and reports a
// per-frame good/bad pulse plus running good/bad counters.
//
// Stream handshake: VALID qualifies DATA/SOF/EOF for exactly one RX_CLK cycle.
// There is no backpressure. SOF and EOF are only meaningful while VALID=1.
// FRM_OK/FRM_BAD/LEN are meaningful only on the VALID&EOF beat.
module gmii_rx_framer #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        RX_CLK,
    input  logic        RST,
    input  logic [7:0]  RXDQ,
    input  logic        RX_DVQ,
    input  logic        RX_ER,
    output logic [7:0]  DATA,
    output logic        VALID,
    output logic        SOF,
    output logic        EOF,
    output logic        FRM_OK,
    output logic        FRM_BAD,
    output logic [15:0] LEN,
    output logic [15:0] CNT_OK,
    output logic [15:0] CNT_BAD,
    output logic [1:0]  DBG_STATE
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    localparam logic [7:0]  PRE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE  = 8'hD5;
    localparam logic [31:0] CRC_POLY  = 32'hEDB88320;
    localparam logic [31:0] CRC_GOOD  = 32'hDEBB20E3;
    localparam logic [15:0] MIN_L     = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L     = 16'(MAX_LEN);

    logic [1:0]  state;
    logic [7:0]  hold_data;
    logic        hold_vld;
    logic        hold_first;
    logic [31:0] crc;
    logic [15:0] len_cnt;
    logic        err;
    logic        rst_dv;      // RX_DVQ was high as reset released; ignore until it drops

    logic [31:0] crc_nxt;
    logic        frame_end;
    logic        frame_bad;

    // Reflected CRC-32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = {1'b0, c[31:1]} ^ (fb ? CRC_POLY : 32'h0);
        end
        return c;
    endfunction

    // Next CRC value and end-of-frame verdict, both derived from current registers.
    always_comb begin
        crc_nxt   = crc32_byte(crc, RXDQ);
        frame_end = hold_vld && !RX_DVQ;
        frame_bad = (crc != CRC_GOOD) || (len_cnt < MIN_L) || (len_cnt > MAX_L) || err;
    end

    assign DBG_STATE = state;

    // Remember whether the line was mid-burst when reset released.
    always_ff @(posedge RX_CLK) begin
        if (RST) begin
            rst_dv <= RX_DVQ;
        end else if (!RX_DVQ) begin
            rst_dv <= 1'b0;
        end
    end

    // Preamble/SFD FSM plus the capture side: hold register, CRC, length, error flag.
    always_ff @(posedge RX_CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            hold_data  <= 8'h00;
            hold_vld   <= 1'b0;
            hold_first <= 1'b0;
            crc        <= 32'hFFFFFFFF;
            len_cnt    <= 16'h0000;
            err        <= 1'b0;
        end else begin
            hold_vld <= 1'b0;
            case (state)
                S_IDLE, S_PRE: begin
                    if (!RX_DVQ) begin
                        state <= S_IDLE;
                    end else if ((state == S_IDLE && rst_dv) || RX_ER) begin
                        state <= S_DROP;
                    end else if (RXDQ == SFD_BYTE) begin
                        state   <= S_DATA;
                        crc     <= 32'hFFFFFFFF;
                        len_cnt <= 16'h0000;
                        err     <= 1'b0;
                    end else if (RXDQ == PRE_BYTE) begin
                        state <= S_PRE;
                    end else begin
                        state <= S_DROP;
                    end
                end
                S_DATA: begin
                    if (!RX_DVQ) begin
                        state <= S_IDLE;
                    end else begin
                        hold_data  <= RXDQ;
                        hold_vld   <= 1'b1;
                        // Length counter saturates, so zero here means first byte after SFD.
                        hold_first <= (len_cnt == 16'h0000);
                        crc        <= crc_nxt;
                        len_cnt    <= (len_cnt == 16'hFFFF) ? len_cnt : len_cnt + 16'd1;
                        if (RX_ER) begin
                            err <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (!RX_DVQ) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Output side: emit the held byte, mark EOF when the input burst ended, report status.
    always_ff @(posedge RX_CLK) begin
        if (RST) begin
            DATA    <= 8'h00;
            VALID   <= 1'b0;
            SOF     <= 1'b0;
            EOF     <= 1'b0;
            FRM_OK  <= 1'b0;
            FRM_BAD <= 1'b0;
            LEN     <= 16'h0000;
            CNT_OK  <= 16'h0000;
            CNT_BAD <= 16'h0000;
        end else begin
            VALID   <= 1'b0;
            SOF     <= 1'b0;
            EOF     <= 1'b0;
            FRM_OK  <= 1'b0;
            FRM_BAD <= 1'b0;
            if (hold_vld) begin
                DATA  <= hold_data;
                VALID <= 1'b1;
                SOF   <= hold_first;
                EOF   <= !RX_DVQ;
            end
            if (frame_end) begin
                LEN <= len_cnt;
                if (frame_bad) begin
                    FRM_BAD <= 1'b1;
                    CNT_BAD <= CNT_BAD + 16'd1;
                end else begin
                    FRM_OK <= 1'b1;
                    CNT_OK <= CNT_OK + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed bench for gmii_rx_framer: builds frames with a locally computed FCS,
// drives them byte by byte, and checks beats, markers, status and counters.
module tb_gmii_rx_framer;

    logic        RX_CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  RXDQ = 8'h00;
    logic        RX_DVQ = 1'b0;
    logic        RX_ER = 1'b0;
    logic [7:0]  DATA;
    logic        VALID;
    logic        SOF;
    logic        EOF;
    logic        FRM_OK;
    logic        FRM_BAD;
    logic [15:0] LEN;
    logic [15:0] CNT_OK;
    logic [15:0] CNT_BAD;
    logic [1:0]  DBG_STATE;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];
    logic       tx_er[$];

    int          beats = 0;
    int          eofs = 0;
    int          oks = 0;
    int          bads = 0;
    logic [15:0] last_len = 16'h0;
    bit          chk_data = 1'b1;
    bit          in_frame = 1'b0;

    gmii_rx_framer #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .RX_CLK(RX_CLK), .RST(RST), .RXDQ(RXDQ), .RX_DVQ(RX_DVQ), .RX_ER(RX_ER),
        .DATA(DATA), .VALID(VALID), .SOF(SOF), .EOF(EOF),
        .FRM_OK(FRM_OK), .FRM_BAD(FRM_BAD), .LEN(LEN),
        .CNT_OK(CNT_OK), .CNT_BAD(CNT_BAD), .DBG_STATE(DBG_STATE)
    );

    // clock / watchdog
    always #5 RX_CLK = ~RX_CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Byte-wise reflected CRC-32 reference.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] r;
        r = c_in ^ {24'h0, d};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Build preamble + SFD + payload(i) + FCS into tx_q; payload+FCS go to exp_q.
    task automatic build_frame(input int n, input int npre, input int flip, input int er_at);
        logic [7:0]  pl[$];
        logic [31:0] c;
        tx_q.delete();
        tx_er.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) begin
            pl.push_back(8'(i));
            c = crc_byte(c, 8'(i));
        end
        c = ~c;
        pl.push_back(c[7:0]);
        pl.push_back(c[15:8]);
        pl.push_back(c[23:16]);
        pl.push_back(c[31:24]);
        if (flip >= 0) pl[flip] = pl[flip] ^ 8'h01;
        for (int i = 0; i < npre; i++) begin
            tx_q.push_back(8'h55);
            tx_er.push_back(1'b0);
        end
        tx_q.push_back(8'hD5);
        tx_er.push_back(1'b0);
        for (int i = 0; i < pl.size(); i++) begin
            tx_q.push_back(pl[i]);
            tx_er.push_back(i == er_at);
            exp_q.push_back(pl[i]);
        end
    endtask

    // driver: one byte per cycle, then RX_DVQ low for gap cycles
    task automatic send(input int gap);
        for (int i = 0; i < tx_q.size(); i++) begin
            @(negedge RX_CLK);
            RXDQ   = tx_q[i];
            RX_DVQ = 1'b1;
            RX_ER  = tx_er[i];
        end
        @(negedge RX_CLK);
        RXDQ   = 8'h00;
        RX_DVQ = 1'b0;
        RX_ER  = 1'b0;
        repeat (gap - 1) @(negedge RX_CLK);
    endtask

    task automatic settle();
        repeat (5) @(negedge RX_CLK);
    endtask

    task automatic clr_stats();
        beats = 0;
        eofs = 0;
        oks = 0;
        bads = 0;
        last_len = 16'h0;
    endtask

    // scoreboard / monitor on the falling edge
    always @(negedge RX_CLK) begin
        if (RST) in_frame = 1'b0;
        checks++;
        assert (!(!VALID && (SOF || EOF))) else begin
            failures++;
            $error("FAIL marker_without_valid observed=sof%0b/eof%0b expected=0/0", SOF, EOF);
        end
        checks++;
        assert ((FRM_OK ^ FRM_BAD) === (VALID & EOF)) else begin
            failures++;
            $error("FAIL status_pulse observed=ok%0b/bad%0b expected_one_pulse=%0b", FRM_OK, FRM_BAD, VALID & EOF);
        end
        if (VALID) begin
            if (chk_data) begin
                checks++;
                assert (exp_q.size() > 0 && DATA === exp_q[0]) else begin
                    failures++;
                    $error("FAIL data observed=%0h expected=%0h", DATA, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                checks++;
                assert (SOF === !in_frame) else begin
                    failures++;
                    $error("FAIL sof observed=%0b expected=%0b", SOF, !in_frame);
                end
            end
            beats++;
            if (EOF) begin
                eofs++;
                last_len = LEN;
            end
            in_frame = !EOF;
        end
        if (FRM_OK) oks++;
        if (FRM_BAD) bads++;
    end

    initial begin
        // reset
        RST = 1'b1;
        repeat (3) @(negedge RX_CLK);
        chk("rst_data", 32'(DATA), 32'h0);
        chk("rst_valid", 32'(VALID), 32'h0);
        chk("rst_sof", 32'(SOF), 32'h0);
        chk("rst_eof", 32'(EOF), 32'h0);
        chk("rst_ok", 32'(FRM_OK), 32'h0);
        chk("rst_bad", 32'(FRM_BAD), 32'h0);
        chk("rst_len", 32'(LEN), 32'h0);
        chk("rst_cnt_ok", 32'(CNT_OK), 32'h0);
        chk("rst_cnt_bad", 32'(CNT_BAD), 32'h0);
        chk("rst_state", 32'(DBG_STATE), 32'h0);
        RST = 1'b0;
        repeat (2) @(negedge RX_CLK);

        // min frame, good FCS
        clr_stats();
        build_frame(64, 7, -1, -1);
        send(1);
        settle();
        chk("min_beats", beats, 64);
        chk("min_eofs", eofs, 1);
        chk("min_ok", oks, 1);
        chk("min_len", 32'(last_len), 64);
        chk("min_cnt_ok", 32'(CNT_OK), 1);
        chk("min_cnt_bad", 32'(CNT_BAD), 0);

        // same frame, bit 0 of payload byte 10 flipped
        clr_stats();
        build_frame(64, 7, 10, -1);
        send(1);
        settle();
        chk("flip_beats", beats, 64);
        chk("flip_bad", bads, 1);
        chk("flip_cnt_bad", 32'(CNT_BAD), 1);
        chk("flip_cnt_ok", 32'(CNT_OK), 1);

        // RX_ER at payload byte 20 of a 100-byte good-FCS frame
        clr_stats();
        build_frame(100, 7, -1, 20);
        send(1);
        settle();
        chk("rxer_bad", bads, 1);
        chk("rxer_len", 32'(last_len), 100);
        chk("rxer_cnt_bad", 32'(CNT_BAD), 2);

        // runt
        clr_stats();
        build_frame(63, 7, -1, -1);
        send(1);
        settle();
        chk("runt_bad", bads, 1);
        chk("runt_len", 32'(last_len), 63);
        chk("runt_cnt_bad", 32'(CNT_BAD), 3);

        // exactly MAX_LEN is legal
        clr_stats();
        build_frame(1518, 7, -1, -1);
        send(1);
        settle();
        chk("max_ok", oks, 1);
        chk("max_len", 32'(last_len), 1518);
        chk("max_cnt_ok", 32'(CNT_OK), 2);

        // giant
        clr_stats();
        build_frame(1519, 7, -1, -1);
        send(1);
        settle();
        chk("giant_beats", beats, 1519);
        chk("giant_bad", bads, 1);
        chk("giant_len", 32'(last_len), 1519);
        chk("giant_cnt_bad", 32'(CNT_BAD), 4);

        // bad preamble dropped, then good frame after 1-cycle gap
        clr_stats();
        tx_q = '{8'h55, 8'h55, 8'h5D, 8'h55, 8'hD5, 8'h00, 8'h01, 8'h02};
        tx_er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        send(1);
        build_frame(64, 7, -1, -1);
        send(1);
        settle();
        chk("drop_beats", beats, 64);
        chk("drop_ok", oks, 1);
        chk("drop_bad", bads, 0);
        chk("drop_cnt_ok", 32'(CNT_OK), 3);
        chk("drop_cnt_bad", 32'(CNT_BAD), 4);

        // back-to-back, 1-cycle gap, second frame with lone SFD
        clr_stats();
        build_frame(64, 7, -1, -1);
        send(1);
        build_frame(70, 0, -1, -1);
        send(1);
        settle();
        chk("b2b_beats", beats, 134);
        chk("b2b_eofs", eofs, 2);
        chk("b2b_ok", oks, 2);
        chk("b2b_len", 32'(last_len), 70);
        chk("b2b_cnt_ok", 32'(CNT_OK), 5);

        // reset mid-payload with RX_DVQ held high
        clr_stats();
        chk_data = 1'b0;
        build_frame(64, 7, -1, -1);
        for (int i = 0; i < 38; i++) begin
            @(negedge RX_CLK);
            RXDQ = tx_q[i];
            RX_DVQ = 1'b1;
        end
        @(negedge RX_CLK);
        RST = 1'b1;
        RXDQ = tx_q[38];
        @(negedge RX_CLK);
        RXDQ = tx_q[39];
        @(negedge RX_CLK);
        RST = 1'b0;
        RXDQ = tx_q[40];
        @(negedge RX_CLK);
        chk("rst_mid_state_drop", 32'(DBG_STATE), 3);
        for (int i = 41; i < 50; i++) begin
            RXDQ = tx_q[i];
            @(negedge RX_CLK);
        end
        RX_DVQ = 1'b0;
        RXDQ = 8'h00;
        settle();
        chk("rst_mid_eofs", eofs, 0);
        chk("rst_mid_ok", oks, 0);
        chk("rst_mid_bad", bads, 0);
        chk("rst_mid_cnt_ok", 32'(CNT_OK), 0);
        chk("rst_mid_cnt_bad", 32'(CNT_BAD), 0);
        chk("rst_mid_state_idle", 32'(DBG_STATE), 0);
        exp_q.delete();
        chk_data = 1'b1;

        // next frame is received normally
        clr_stats();
        build_frame(64, 7, -1, -1);
        send(1);
        settle();
        chk("post_beats", beats, 64);
        chk("post_ok", oks, 1);
        chk("post_len", 32'(last_len), 64);
        chk("post_cnt_ok", 32'(CNT_OK), 1);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
